// File: rtl/klein_pkg.sv
// Shared constants, S-box and FSM state type for the KLEIN-80 decryption
// key schedule.
package klein_pkg;

  localparam int unsigned KLEIN_KEY_W  = 80;
  localparam int unsigned KLEIN_ROUNDS = 16;

  // Nibble i of this word is S(i); the table reads 7,4,A,9,1,F,B,0,C,3,2,6,8,E,D,5
  // from input 0 upward, stored LSB-first so the input nibble indexes it directly.
  localparam logic [63:0] SBOX = 64'h5DE8_623C_0BF1_9A47;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } klein_state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] n);
    return SBOX[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] sbox8(input logic [7:0] b);
    return {sbox4(b[7:4]), sbox4(b[3:0])};
  endfunction

endpackage

// File: rtl/klein_inv_key_round.sv
// Combinational inverse of one KLEIN-80 key-schedule round: given the key
// after round rc, recover the key before it.
module klein_inv_key_round
  import klein_pkg::*;
(
  input  logic [KLEIN_KEY_W-1:0] key_i,
  input  logic [7:0]             rc_i,
  output logic [KLEIN_KEY_W-1:0] key_o
);

  logic [39:0] a_n;
  logic [39:0] b_n;
  logic [39:0] b_rot;
  logic [39:0] t;
  logic [39:0] a_rot;

  // The forward round XORs rc into byte 2 of the new A and runs bytes 1-2 of
  // the new B through S; S is an involution, so both steps undo themselves.
  always_comb begin
    a_n   = key_i[79:40];
    b_n   = key_i[39:0];

    b_rot          = a_n;
    b_rot[23:16]   = a_n[23:16] ^ rc_i;

    t              = b_n;
    t[31:24]       = sbox8(b_n[31:24]);
    t[23:16]       = sbox8(b_n[23:16]);

    a_rot          = t ^ b_rot;

    key_o = {a_rot[7:0], a_rot[39:8], b_rot[7:0], b_rot[39:8]};
  end

endmodule

// File: rtl/klein_dec_key_sched.sv
// KLEIN-80 decryption key scheduler: loads the final schedule key and emits
// subkeys ROUNDS..0 one per handshake, undoing one round per accepted key.
module klein_dec_key_sched
  import klein_pkg::*;
#(
  parameter int unsigned ROUNDS = KLEIN_ROUNDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KLEIN_KEY_W-1:0] final_key,
  output logic                   busy,
  output logic                   rk_valid,
  input  logic                   rk_ready,
  output logic [KLEIN_KEY_W-1:0] round_key,
  output logic [4:0]             rk_index,
  output logic                   done
);

  klein_state_e           state_q, state_d;
  logic [KLEIN_KEY_W-1:0] key_q, key_d;
  logic [4:0]             idx_q, idx_d;
  logic [KLEIN_KEY_W-1:0] prev_key;

  klein_inv_key_round u_inv_round (
    .key_i (key_q),
    .rc_i  ({3'b000, idx_q}),
    .key_o (prev_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = final_key;
          idx_d   = 5'(ROUNDS);
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (idx_q != '0) begin
            key_d = prev_key;
            idx_d = idx_q - 5'd1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q == ST_EMIT);
  assign rk_valid  = (state_q == ST_EMIT);
  assign done      = (state_q == ST_DONE);
  assign round_key = key_q;
  assign rk_index  = idx_q;

endmodule

// File: tb/tb_klein_dec_key_sched.sv
// Bench for klein_dec_key_sched: forward-schedule reference feeding a
// scoreboard of expected (index, key) pairs, plus a standalone inverse-round check.
module tb_klein_dec_key_sched;

  localparam int ROUNDS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [79:0] final_key;
  logic        busy;
  logic        rk_valid;
  logic        rk_ready;
  logic [79:0] round_key;
  logic [4:0]  rk_index;
  logic        done;

  logic [79:0] inv_key;
  logic [7:0]  inv_rc;
  logic [79:0] inv_out;

  int checks = 0;
  int errors = 0;

  logic [79:0] exp_key_q[$];
  int          exp_idx_q[$];

  always #5 clk = ~clk;

  klein_dec_key_sched #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .final_key (final_key),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .rk_index  (rk_index),
    .done      (done)
  );

  klein_inv_key_round u_inv (
    .key_i (inv_key),
    .rc_i  (inv_rc),
    .key_o (inv_out)
  );

  function automatic logic [3:0] ref_s4(input logic [3:0] n);
    case (n)
      4'h0: return 4'h7;  4'h1: return 4'h4;  4'h2: return 4'hA;  4'h3: return 4'h9;
      4'h4: return 4'h1;  4'h5: return 4'hF;  4'h6: return 4'hB;  4'h7: return 4'h0;
      4'h8: return 4'hC;  4'h9: return 4'h3;  4'hA: return 4'h2;  4'hB: return 4'h6;
      4'hC: return 4'h8;  4'hD: return 4'hE;  4'hE: return 4'hD;  default: return 4'h5;
    endcase
  endfunction

  function automatic logic [7:0] ref_s8(input logic [7:0] b);
    return {ref_s4(b[7:4]), ref_s4(b[3:0])};
  endfunction

  function automatic logic [79:0] fwd_round(input logic [79:0] k, input logic [7:0] r);
    logic [39:0] a, b, ap, bp, an, bn;
    a  = k[79:40];
    b  = k[39:0];
    ap = {a[31:0], a[39:32]};
    bp = {b[31:0], b[39:32]};
    an = bp;
    an[23:16] = an[23:16] ^ r;
    bn = ap ^ bp;
    bn[31:24] = ref_s8(bn[31:24]);
    bn[23:16] = ref_s8(bn[23:16]);
    return {an, bn};
  endfunction

  task automatic load_expected(input logic [79:0] master, output logic [79:0] fin);
    logic [79:0] ks[ROUNDS+1];
    ks[0] = master;
    for (int r = 1; r <= ROUNDS; r++) ks[r] = fwd_round(ks[r-1], 8'(r));
    for (int i = ROUNDS; i >= 0; i--) begin
      exp_key_q.push_back(ks[i]);
      exp_idx_q.push_back(i);
    end
    fin = ks[ROUNDS];
  endtask

  task automatic drive_start(input logic [79:0] fin);
    @(negedge clk);
    final_key = fin;
    start     = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; final_key = '0;
    inv_key = '0; inv_rc = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, rk_valid, done, rk_index, round_key} !== '0)
      begin errors++; $display("FAIL reset_outputs: got busy=%b valid=%b done=%b idx=%0d key=%h, want all 0",
        busy, rk_valid, done, rk_index, round_key); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: got busy=%b valid=%b, want 0 0", busy, rk_valid); end
  endtask

  task automatic test_roundtrip(input logic [79:0] master);
    logic [79:0] fin;
    logic [79:0] ek;
    int          ei;
    bit          seen_done;
    seen_done = 0;
    load_expected(master, fin);
    rk_ready = 1'b1;
    drive_start(fin);
    for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rk_valid === 1'b1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rt_busy: got %b want 1 at cycle %0d", busy, cyc); end
        if (exp_key_q.size() == 0) begin
          checks++; errors++; $display("FAIL rt_extra_key: got idx %0d, want no key", rk_index);
        end else begin
          ek = exp_key_q.pop_front(); ei = exp_idx_q.pop_front();
          checks++;
          if (rk_index !== 5'(ei)) begin errors++; $display("FAIL rt_index: got %0d want %0d", rk_index, ei); end
          checks++;
          if (round_key !== ek) begin errors++; $display("FAIL rt_key[%0d]: got %h want %h", ei, round_key, ek); end
          if (ei == 0 && master == 80'h0) begin
            checks++;
            if (round_key !== 80'h0) begin errors++; $display("FAIL rt_master_zero: got %h want 0", round_key); end
          end
        end
      end
      if (done === 1'b1) begin
        seen_done = 1;
        checks++;
        if (cyc != ROUNDS + 2) begin errors++; $display("FAIL rt_done_cycle: got %0d want %0d", cyc, ROUNDS + 2); end
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0)
          begin errors++; $display("FAIL rt_done_flags: got busy=%b valid=%b want 0 0", busy, rk_valid); end
        checks++;
        if (exp_key_q.size() != 0)
          begin errors++; $display("FAIL rt_missing_keys: got %0d left want 0", exp_key_q.size()); end
      end
    end
    if (!seen_done) begin checks++; errors++; $display("FAIL rt_timeout: got no done within 40 cycles, want done"); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rt_done_pulse: got done=%b want 0 after one cycle", done); end
  endtask

  task automatic test_backpressure(input logic [79:0] master);
    logic [79:0] fin, ek, hold_key;
    logic [4:0]  hold_idx;
    int          ei, stall9;
    bit          seen_done, stalled;
    seen_done = 0; stalled = 0; stall9 = 0;
    load_expected(master, fin);
    drive_start(fin);
    for (int cyc = 1; cyc <= 300 && !seen_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (stalled) begin
        checks++;
        if (rk_valid !== 1'b1 || rk_index !== hold_idx || round_key !== hold_key)
          begin errors++; $display("FAIL bp_hold: got valid=%b idx=%0d key=%h want 1 %0d %h",
            rk_valid, rk_index, round_key, hold_idx, hold_key); end
      end
      if (rk_valid === 1'b1 && rk_index == 5'd9 && stall9 < 3) begin
        rk_ready = 1'b0; stall9++;
      end else begin
        rk_ready = ($urandom_range(0, 3) != 0);
      end
      stalled = (rk_valid === 1'b1) && !rk_ready;
      hold_key = round_key; hold_idx = rk_index;
      if (rk_valid === 1'b1 && rk_ready) begin
        if (exp_key_q.size() == 0) begin
          checks++; errors++; $display("FAIL bp_extra_key: got idx %0d, want no key", rk_index);
        end else begin
          ek = exp_key_q.pop_front(); ei = exp_idx_q.pop_front();
          checks++;
          if (rk_index !== 5'(ei) || round_key !== ek)
            begin errors++; $display("FAIL bp_key: got idx %0d key %h want idx %0d key %h", rk_index, round_key, ei, ek); end
        end
      end
      if (done === 1'b1) begin
        seen_done = 1;
        checks++;
        if (exp_key_q.size() != 0 || stall9 != 3)
          begin errors++; $display("FAIL bp_complete: got %0d left, %0d stalls want 0 left, 3 stalls", exp_key_q.size(), stall9); end
      end
    end
    if (!seen_done) begin checks++; errors++; $display("FAIL bp_timeout: got no done within 300 cycles, want done"); end
    rk_ready = 1'b1;
  endtask

  task automatic test_start_ignored(input logic [79:0] master, input logic [79:0] other);
    logic [79:0] fin, ek;
    int          ei;
    bit          seen_done, injected;
    seen_done = 0; injected = 0;
    load_expected(master, fin);
    rk_ready = 1'b1;
    drive_start(fin);
    for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rk_valid === 1'b1) begin
        if (exp_key_q.size() == 0) begin
          checks++; errors++; $display("FAIL si_extra_key: got idx %0d, want no key", rk_index);
        end else begin
          ek = exp_key_q.pop_front(); ei = exp_idx_q.pop_front();
          checks++;
          if (rk_index !== 5'(ei) || round_key !== ek)
            begin errors++; $display("FAIL si_key: got idx %0d key %h want idx %0d key %h", rk_index, round_key, ei, ek); end
        end
        if (rk_index == 5'd7 && !injected) begin
          injected = 1; start = 1'b1; final_key = other;
        end
      end
      if (done === 1'b1) begin
        seen_done = 1;
        checks++;
        if (cyc != ROUNDS + 2) begin errors++; $display("FAIL si_done_cycle: got %0d want %0d", cyc, ROUNDS + 2); end
        start = 1'b1; final_key = other;
      end
    end
    if (!seen_done) begin checks++; errors++; $display("FAIL si_timeout: got no done within 40 cycles, want done"); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
        begin errors++; $display("FAIL si_done_start: got valid=%b busy=%b done=%b want 0 0 0", rk_valid, busy, done); end
    end
  endtask

  task automatic test_reset_midseq(input logic [79:0] master, input logic [79:0] master2);
    logic [79:0] fin;
    bit          hit;
    hit = 0;
    load_expected(master, fin);
    rk_ready = 1'b1;
    drive_start(fin);
    for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rk_valid === 1'b1 && rk_index == 5'd5) begin
        hit = 1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rk_valid, done, rk_index, round_key} !== '0)
          begin errors++; $display("FAIL mid_reset: got busy=%b valid=%b done=%b idx=%0d key=%h want all 0",
            busy, rk_valid, done, rk_index, round_key); end
      end
    end
    if (!hit) begin checks++; errors++; $display("FAIL mid_reset_timeout: got no index 5 within 40 cycles"); end
    exp_key_q.delete();
    exp_idx_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    test_roundtrip(master2);
  endtask

  task automatic test_inv_round();
    logic [79:0] k, f;
    logic [7:0]  r;
    for (int n = 0; n < 1000; n++) begin
      k = {$urandom(), $urandom(), 16'($urandom())};
      r = 8'($urandom_range(1, 16));
      f = fwd_round(k, r);
      inv_key = f; inv_rc = r;
      #1;
      checks++;
      if (inv_out !== k)
        begin errors++; $display("FAIL inv_round r=%0d: got %h want %h", r, inv_out, k); end
    end
  endtask

  initial begin
    test_reset();
    test_roundtrip(80'h0);
    test_roundtrip(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    test_roundtrip(80'h1234_5678_9ABC_DEF0_1234);
    test_backpressure(80'hA5A5_0F0F_3C3C_9669_C33C);
    test_start_ignored(80'h0123_4567_89AB_CDEF_FEDC, 80'hDEAD_BEEF_CAFE_F00D_BEEF);
    test_reset_midseq(80'h1111_2222_3333_4444_5555, 80'h1234_5678_9ABC_DEF0_1234);
    test_inv_round();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
